if_id_skid: RTL and testbench

IF_ID_SKID -- requirements
Module: if_id_skid

---
 rtl/if_id_skid_if.sv | 27 ++
 rtl/if_id_skid.sv | 108 ++++++++++
 tb/tb_if_id_skid.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_if.sv
// Handshake bundle between the fetch stage, the IF/ID skid buffer and decode.
// master = the fetch/decode side driving the buffer, slave = the buffer itself.
interface if_id_skid_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
) ();
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic [1:0]         occupancy;

  modport master (
    output flush, in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, occupancy
  );

  modport slave (
    input  flush, in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, instr_out, pc_out, occupancy
  );
endinterface

// File: rtl/if_id_skid.sv
// Two-entry IF/ID skid buffer: head register feeds decode, skid register absorbs
// the entry accepted while decode stalls, so in_ready depends on state alone.
module if_id_skid #(
  parameter int unsigned        INSTR_W = 32,
  parameter int unsigned        PC_W    = 32,
  parameter logic [INSTR_W-1:0] BUBBLE  = INSTR_W'(32'h00000013)
) (
  input logic          clk,
  input logic          reset,
  if_id_skid_if.slave  bus
);

  // Encoding equals the occupancy count, so outputs decode straight from state_q.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               in_fire;
  logic               out_fire;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.occupancy = state_q;
  assign bus.instr_out = head_instr_q;
  assign bus.pc_out    = head_pc_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      head_instr_q <= BUBBLE;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Next-state and datapath; flush overrides every handshake event
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    in_fire      = bus.in_valid & (state_q != FULL);
    out_fire     = (state_q != EMPTY) & bus.out_ready;

    if (bus.flush) begin
      state_d      = EMPTY;
      head_instr_d = BUBBLE;
      head_pc_d    = '0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            head_instr_d = bus.instr_in;
            head_pc_d    = bus.pc_in;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_instr_d = bus.instr_in;
            head_pc_d    = bus.pc_in;
          end else if (in_fire) begin
            state_d      = FULL;
            skid_instr_d = bus.instr_in;
            skid_pc_d    = bus.pc_in;
          end else if (out_fire) begin
            state_d      = EMPTY;
            head_instr_d = BUBBLE;
            head_pc_d    = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d      = ONE;
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
            skid_instr_d = '0;
            skid_pc_d    = '0;
          end
        end
        default: begin
          state_d      = EMPTY;
          head_instr_d = BUBBLE;
          head_pc_d    = '0;
          skid_instr_d = '0;
          skid_pc_d    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table, hand sequences for reset/flush/width
// corners, and random traffic scored against a queue model of the buffer.
module tb_if_id_skid;

  localparam logic [31:0] BUB0 = 32'h00000013;
  localparam logic [15:0] BUB1 = 16'h0001;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_id_skid_if #(.INSTR_W(32), .PC_W(32)) b0 ();
  if_id_skid_if #(.INSTR_W(16), .PC_W(12)) b1 ();

  if_id_skid #(.INSTR_W(32), .PC_W(32), .BUBBLE(BUB0)) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  if_id_skid #(.INSTR_W(16), .PC_W(12), .BUBBLE(BUB1)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [1:0]  e_occ;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  vec_t tbl[15];
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check0(input string name, input logic ov, input logic ir,
                        input logic [31:0] ins, input logic [31:0] pc, input logic [1:0] occ);
    chk({name, "_out_valid"}, 32'(b0.out_valid), 32'(ov));
    chk({name, "_in_ready"},  32'(b0.in_ready),  32'(ir));
    chk({name, "_instr_out"}, b0.instr_out,      ins);
    chk({name, "_pc_out"},    b0.pc_out,         pc);
    chk({name, "_occupancy"}, 32'(b0.occupancy), 32'(occ));
  endtask

  task automatic drv0(input logic fl, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy);
    b0.flush = fl; b0.in_valid = iv; b0.instr_in = ins; b0.pc_in = pc; b0.out_ready = ordy;
  endtask

  task automatic drv1(input logic iv, input logic [15:0] ins, input logic [11:0] pc,
                      input logic ordy);
    b1.flush = 1'b0; b1.in_valid = iv; b1.instr_in = ins; b1.pc_in = pc; b1.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // after-edge expectations for the directed table
    tbl[0]  = '{1'b0, 1'b1, 32'h00500093, 32'h00, 1'b1, 1'b1, 1'b1, 32'h00500093, 32'h00, 2'd1};
    tbl[1]  = '{1'b0, 1'b0, 32'hDEADBEEF, 32'hFC, 1'b1, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'hAAAA0001, 32'h04, 1'b0, 1'b1, 1'b1, 32'hAAAA0001, 32'h04, 2'd1};
    tbl[3]  = '{1'b0, 1'b1, 32'hBBBB0002, 32'h08, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h04, 2'd2};
    tbl[4]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h0C, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h04, 2'd2};
    tbl[5]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h0C, 1'b1, 1'b1, 1'b1, 32'hBBBB0002, 32'h08, 2'd1};
    tbl[6]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h0C, 1'b1, 1'b1, 1'b1, 32'hCCCC0003, 32'h0C, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 32'h12345678, 32'h99, 1'b1, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 32'hA1A1A1A1, 32'h10, 1'b0, 1'b1, 1'b1, 32'hA1A1A1A1, 32'h10, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'hB2B2B2B2, 32'h14, 1'b0, 1'b1, 1'b0, 32'hA1A1A1A1, 32'h10, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 32'hC3C3C3C3, 32'h18, 1'b0, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 32'hC3C3C3C3, 32'h18, 1'b1, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};
    tbl[12] = '{1'b0, 1'b1, 32'hD4D4D4D4, 32'h20, 1'b0, 1'b1, 1'b1, 32'hD4D4D4D4, 32'h20, 2'd1};
    tbl[13] = '{1'b1, 1'b1, 32'hE5E5E5E5, 32'h24, 1'b1, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};
    tbl[14] = '{1'b0, 1'b0, 32'hE5E5E5E5, 32'h24, 1'b1, 1'b0, 1'b1, BUB0,         32'h00, 2'd0};

    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drv1(1'b0, 16'h0, 12'h0, 1'b0);

    // asynchronous reset visible before any clock edge
    #2 reset = 1'b1;
    #1;
    check0("reset_async", 1'b0, 1'b1, BUB0, 32'h0, 2'd0);
    chk("reset_w16_instr", 32'(b1.instr_out), 32'(BUB1));
    chk("reset_w16_pc",    32'(b1.pc_out),    32'h0);
    chk("reset_w16_occ",   32'(b1.occupancy), 32'h0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drv0(tbl[i].fl, tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].ordy);
      step();
      check0($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_ins, tbl[i].e_pc,
             tbl[i].e_occ);
    end

    // full-rate streaming keeps one entry resident with no gaps
    for (int i = 0; i < 8; i++) begin
      drv0(1'b0, 1'b1, 32'h10000000 + 32'(i), 32'(i * 4), 1'b1);
      step();
      check0($sformatf("stream%0d", i), 1'b1, 1'b1, 32'h10000000 + 32'(i), 32'(i * 4), 2'd1);
    end
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check0("stream_drain", 1'b0, 1'b1, BUB0, 32'h0, 2'd0);

    // reset pulsed between edges while FULL
    drv0(1'b0, 1'b1, 32'h30303030, 32'h30, 1'b0);
    step();
    drv0(1'b0, 1'b1, 32'h34343434, 32'h34, 1'b0);
    step();
    check0("pre_rst_full", 1'b1, 1'b0, 32'h30303030, 32'h30, 2'd2);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    check0("rst_mid", 1'b0, 1'b1, BUB0, 32'h0, 2'd0);
    step();
    reset = 1'b0;
    drv0(1'b0, 1'b1, 32'h40404040, 32'h40, 1'b0);
    step();
    check0("post_rst_push", 1'b1, 1'b1, 32'h40404040, 32'h40, 2'd1);
    drv0(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check0("post_rst_drain", 1'b0, 1'b1, BUB0, 32'h0, 2'd0);
    step();
    check0("post_rst_idle", 1'b0, 1'b1, BUB0, 32'h0, 2'd0);

    // narrow instance keeps ordering under backpressure
    drv1(1'b1, 16'hA001, 12'h004, 1'b0);
    step();
    chk("w16_a_pc", 32'(b1.pc_out), 32'h004);
    drv1(1'b1, 16'hB002, 12'h008, 1'b0);
    step();
    chk("w16_full_occ",   32'(b1.occupancy), 32'd2);
    chk("w16_full_ready", 32'(b1.in_ready),  32'd0);
    chk("w16_head_pc",    32'(b1.pc_out),    32'h004);
    drv1(1'b1, 16'hC003, 12'h00C, 1'b1);
    step();
    chk("w16_b_pc",    32'(b1.pc_out),    32'h008);
    chk("w16_b_instr", 32'(b1.instr_out), 32'hB002);
    step();
    chk("w16_c_pc",    32'(b1.pc_out),    32'h00C);
    chk("w16_c_instr", 32'(b1.instr_out), 32'hC003);
    drv1(1'b0, 16'h0, 12'h0, 1'b1);
    step();
    chk("w16_empty_instr", 32'(b1.instr_out), 32'(BUB1));
    chk("w16_empty_valid", 32'(b1.out_valid), 32'd0);

    // random traffic against a FIFO-of-two model
    mq.delete();
    for (int n = 0; n < 600; n++) begin
      logic        r_rst, r_fl, r_iv, r_or, m_ir, m_ov;
      logic [31:0] r_ins, r_pc, e_ins, e_pc;
      ent_t        e;
      r_rst = ($urandom_range(0, 49) == 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      r_iv  = $urandom_range(0, 3) != 0;
      r_or  = $urandom_range(0, 2) != 0;
      r_ins = $urandom;
      r_pc  = $urandom;
      drv0(r_fl, r_iv, r_ins, r_pc, r_or);
      reset = r_rst;
      m_ir = (mq.size() < 2);
      m_ov = (mq.size() > 0);
      if (r_rst || r_fl) begin
        mq.delete();
      end else begin
        if (m_ov && r_or) void'(mq.pop_front());
        if (r_iv && m_ir) begin
          e.ins = r_ins;
          e.pc  = r_pc;
          mq.push_back(e);
        end
      end
      step();
      e_ins = (mq.size() > 0) ? mq[0].ins : BUB0;
      e_pc  = (mq.size() > 0) ? mq[0].pc  : 32'h0;
      check0($sformatf("rnd%0d", n), mq.size() > 0, mq.size() < 2, e_ins, e_pc,
             2'(mq.size()));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
